fft4_frame_ctrl: RTL

//   Sequencer for the combinational FFT4 datapath. Collects a serial stream of real

---
 rtl/fft4_frame_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fft4_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft4_frame_ctrl : frames serial samples for an external FFT4 and streams   |
// |                   its four registered output bins over valid/ready.         |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module fft4_frame_ctrl #(
   parameter int PRE        = 16,
   parameter bit CONTINUOUS = 1'b0
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic                  Start,
   input  logic                  In_Valid,
   input  logic signed [PRE:0]   In_Data,
   output logic                  In_Ready,
   output logic signed [PRE:0]   X0,
   output logic signed [PRE:0]   X1,
   output logic signed [PRE:0]   X2,
   output logic signed [PRE:0]   X3,
   input  logic signed [2*PRE:0] Y0_Re,
   input  logic signed [2*PRE:0] Y1_Re,
   input  logic signed [2*PRE:0] Y2_Re,
   input  logic signed [2*PRE:0] Y3_Re,
   input  logic signed [2*PRE:0] Y0_Im,
   input  logic signed [2*PRE:0] Y1_Im,
   input  logic signed [2*PRE:0] Y2_Im,
   input  logic signed [2*PRE:0] Y3_Im,
   output logic                  Out_Valid,
   input  logic                  Out_Ready,
   output logic signed [2*PRE:0] Out_Re,
   output logic signed [2*PRE:0] Out_Im,
   output logic [1:0]            Out_Idx,
   output logic                  Out_Last,
   output logic                  Busy,
   output logic                  Done
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOAD   = 2'd1,
      S_SETTLE = 2'd2,
      S_DRAIN  = 2'd3
   } state_t;

   state_t                r_state;
   logic [1:0]            r_cnt;
   logic signed [2*PRE:0] r_bre [4];
   logic signed [2*PRE:0] r_bim [4];
   logic [1:0]            w_next_idx;

   assign w_next_idx = Out_Idx + 2'd1;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 2'd0;
         In_Ready  <= 1'b0;
         X0        <= '0;
         X1        <= '0;
         X2        <= '0;
         X3        <= '0;
         Out_Valid <= 1'b0;
         Out_Re    <= '0;
         Out_Im    <= '0;
         Out_Idx   <= 2'd0;
         Out_Last  <= 1'b0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            r_bre[i] <= '0;
            r_bim[i] <= '0;
         end
      end else begin
         Done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_state  <= S_LOAD;
                  r_cnt    <= 2'd0;
                  In_Ready <= 1'b1;
                  Busy     <= 1'b1;
               end
            end
            S_LOAD: begin
               if (In_Valid && In_Ready) begin
                  case (r_cnt)
                     2'd0:    X0 <= In_Data;
                     2'd1:    X1 <= In_Data;
                     2'd2:    X2 <= In_Data;
                     default: X3 <= In_Data;
                  endcase
                  r_cnt <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     r_state  <= S_SETTLE;
                     In_Ready <= 1'b0;
                  end
               end
            end
            S_SETTLE: begin
               // X0..X3 have been stable a full cycle; the FFT4 result is valid now.
               r_bre[0]  <= Y0_Re;
               r_bre[1]  <= Y1_Re;
               r_bre[2]  <= Y2_Re;
               r_bre[3]  <= Y3_Re;
               r_bim[0]  <= Y0_Im;
               r_bim[1]  <= Y1_Im;
               r_bim[2]  <= Y2_Im;
               r_bim[3]  <= Y3_Im;
               Out_Re    <= Y0_Re;
               Out_Im    <= Y0_Im;
               Out_Idx   <= 2'd0;
               Out_Last  <= 1'b0;
               Out_Valid <= 1'b1;
               r_state   <= S_DRAIN;
            end
            default: begin
               if (Out_Ready) begin
                  if (Out_Idx == 2'd3) begin
                     Out_Valid <= 1'b0;
                     Out_Last  <= 1'b0;
                     Out_Idx   <= 2'd0;
                     Done      <= 1'b1;
                     if (CONTINUOUS) begin
                        r_state  <= S_LOAD;
                        In_Ready <= 1'b1;
                     end else begin
                        r_state <= S_IDLE;
                        Busy    <= 1'b0;
                     end
                  end else begin
                     // Preload the next bin so the data output stays registered.
                     Out_Idx  <= w_next_idx;
                     Out_Re   <= r_bre[w_next_idx];
                     Out_Im   <= r_bim[w_next_idx];
                     Out_Last <= (w_next_idx == 2'd3);
                  end
               end
            end
         endcase
      end
   end

endmodule
`default_nettype wire
